// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate extender: mode encoding and the
// decoded result record carried through the output skid buffer.
package imm_pkg;

    localparam int INSTR_W       = 24;
    localparam int IMM_MAX_W     = 64;
    localparam int IMM_TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10,
        IMM_ILL = 2'b11
    } imm_src_e;

    // Fields are sized for the widest legal configuration; users take the low
    // DATA_W / TAG_W bits and the unused upper bits are always zero.
    typedef struct packed {
        logic [IMM_MAX_W-1:0]     ext_imm;
        logic                     carry;
        logic                     carry_vld;
        logic                     illegal;
        logic [IMM_TAG_MAX_W-1:0] tag;
    } imm_result_t;

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational immediate decoder: maps instruction bits and mode to a result
// record (extended immediate, rotator carry, illegal flag, tag).
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_src_e           imm_src,
    input  logic [TAG_W-1:0]   tag,
    output imm_result_t        result
);

    logic [3:0]        rot;
    logic [4:0]        rot_sh;
    logic [DATA_W-1:0] imm8_z;
    logic [DATA_W-1:0] dp_imm;
    logic [DATA_W-1:0] mem_imm;
    logic [DATA_W-1:0] br_imm;

    assign rot     = instr[11:8];
    assign rot_sh  = {rot, 1'b0};
    assign imm8_z  = {{(DATA_W-8){1'b0}}, instr[7:0]};
    // A left shift by DATA_W yields zero, so rot == 0 degenerates cleanly.
    assign dp_imm  = (imm8_z >> rot_sh) | (imm8_z << (DATA_W - int'(rot_sh)));
    assign mem_imm = {{(DATA_W-12){1'b0}}, instr[11:0]};
    assign br_imm  = {{(DATA_W-26){instr[23]}}, instr, 2'b00};

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch.
        result = '0;
        result.tag[TAG_W-1:0] = tag;
        unique case (imm_src)
            IMM_DP: begin
                result.ext_imm[DATA_W-1:0] = dp_imm;
                result.carry_vld           = (rot != 4'd0);
                result.carry               = (rot != 4'd0) && dp_imm[DATA_W-1];
            end
            IMM_MEM: result.ext_imm[DATA_W-1:0] = mem_imm;
            IMM_BR:  result.ext_imm[DATA_W-1:0] = br_imm;
            IMM_ILL: result.illegal = 1'b1;
            default: result.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: decodes one request per cycle into a main
// output register backed by a one-entry skid register, plus an illegal counter.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         imm_src,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ext_imm,
    output logic               imm_carry,
    output logic               imm_carry_vld,
    output logic               illegal,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   illegal_cnt
);

    imm_result_t dec_res;
    imm_result_t main_q;
    imm_result_t skid_q;
    logic        main_vld, main_vld_d;
    logic        skid_vld, skid_vld_d;
    logic        in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept, consume;
    logic load_main_dec, load_main_skid, load_skid;
    logic unused_hi;

    imm_decode #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_decode (
        .instr   (instr),
        .imm_src (imm_src_e'(imm_src)),
        .tag     (in_tag),
        .result  (dec_res)
    );

    assign accept  = in_valid && in_ready_q;
    assign consume = main_vld && out_ready;

    // Skid can only be full while in_ready is low, so accept never meets a
    // consume that is draining the skid.
    always_comb begin
        main_vld_d     = main_vld;
        skid_vld_d     = skid_vld;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (consume) begin
            if (skid_vld) begin
                load_main_skid = 1'b1;
                skid_vld_d     = 1'b0;
            end else if (accept) begin
                load_main_dec = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                load_main_dec = 1'b1;
                main_vld_d    = 1'b1;
            end else begin
                load_skid  = 1'b1;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            cnt_q      <= '0;
        end else begin
            main_vld   <= main_vld_d;
            skid_vld   <= skid_vld_d;
            in_ready_q <= !skid_vld_d;
            if (load_main_dec) begin
                main_q <= dec_res;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (accept && dec_res.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: skid data is qualified by skid_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= dec_res;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_vld;
    assign ext_imm       = main_q.ext_imm[DATA_W-1:0];
    assign imm_carry     = main_q.carry;
    assign imm_carry_vld = main_q.carry_vld;
    assign illegal       = main_q.illegal;
    assign out_tag       = main_q.tag[TAG_W-1:0];
    assign illegal_cnt   = cnt_q;

    assign unused_hi = ^{main_q.ext_imm, main_q.tag};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance driven by the same stimulus.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] instr = '0;
    logic [1:0]  imm_src = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, imm_carry, imm_carry_vld, illegal;
    logic [31:0] ext_imm;
    logic [3:0]  out_tag;
    logic [15:0] illegal_cnt;

    logic        in_ready_w, out_valid_w, imm_carry_w, imm_carry_vld_w, illegal_w;
    logic [63:0] ext_imm_w;
    logic [3:0]  out_tag_w;
    logic [1:0]  illegal_cnt_w;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_W(32), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .ext_imm(ext_imm),
        .imm_carry(imm_carry), .imm_carry_vld(imm_carry_vld), .illegal(illegal),
        .out_tag(out_tag), .illegal_cnt(illegal_cnt)
    );

    imm_extend_pipe #(.DATA_W(64), .TAG_W(4), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(out_valid_w), .out_ready(out_ready), .ext_imm(ext_imm_w),
        .imm_carry(imm_carry_w), .imm_carry_vld(imm_carry_vld_w), .illegal(illegal_w),
        .out_tag(out_tag_w), .illegal_cnt(illegal_cnt_w)
    );

    // Presents one request, waits (bounded) for acceptance, and returns at the
    // negedge of the cycle in which the result should be visible.
    task automatic do_req(input logic [1:0] m, input logic [23:0] ins, input logic [3:0] t);
        @(negedge clk);
        in_valid = 1'b1; imm_src = m; instr = ins; in_tag = t;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL accept_timeout tag=%0d in_ready=%b required 1", t, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b1 || out_tag !== t) begin
            mismatched++;
            $display("FAIL latency tag=%0d out_valid=%b out_tag=%0d required 1/%0d", t, out_valid, out_tag, t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({out_valid, in_ready, ext_imm, imm_carry, imm_carry_vld, illegal, out_tag, illegal_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_state out_valid=%b in_ready=%b ext_imm=%h carry=%b vld=%b ill=%b tag=%h cnt=%0d required all 0",
                     out_valid, in_ready, ext_imm, imm_carry, imm_carry_vld, illegal, out_tag, illegal_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_dp();
        do_req(2'b00, 24'h0004FF, 4'h1);
        compared++;
        if (ext_imm !== 32'hFF000000 || imm_carry !== 1'b1 || imm_carry_vld !== 1'b1 || illegal !== 1'b0) begin
            mismatched++;
            $display("FAIL dp_rot4 ext_imm=%h carry=%b vld=%b ill=%b required ff000000/1/1/0", ext_imm, imm_carry, imm_carry_vld, illegal);
        end
        compared++;
        if (ext_imm_w !== 64'hFF00000000000000 || imm_carry_w !== 1'b1) begin
            mismatched++;
            $display("FAIL dp_rot4_w64 ext_imm=%h carry=%b required ff00000000000000/1", ext_imm_w, imm_carry_w);
        end
        do_req(2'b00, 24'h00007F, 4'h2);
        compared++;
        if (ext_imm !== 32'h0000007F || imm_carry !== 1'b0 || imm_carry_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL dp_rot0 ext_imm=%h carry=%b vld=%b required 0000007f/0/0", ext_imm, imm_carry, imm_carry_vld);
        end
        do_req(2'b00, 24'h000F01, 4'h3);
        compared++;
        if (ext_imm !== 32'h00000004 || imm_carry !== 1'b0 || imm_carry_vld !== 1'b1) begin
            mismatched++;
            $display("FAIL dp_rot15 ext_imm=%h carry=%b vld=%b required 00000004/0/1", ext_imm, imm_carry, imm_carry_vld);
        end
        do_req(2'b00, 24'h0001FF, 4'h4);
        compared++;
        if (ext_imm !== 32'hC000003F || imm_carry !== 1'b1 || imm_carry_vld !== 1'b1) begin
            mismatched++;
            $display("FAIL dp_rot1 ext_imm=%h carry=%b vld=%b required c000003f/1/1", ext_imm, imm_carry, imm_carry_vld);
        end
    endtask

    task automatic test_mem();
        do_req(2'b01, 24'hFFFABC, 4'h5);
        compared++;
        if (ext_imm !== 32'h00000ABC || imm_carry_vld !== 1'b0 || imm_carry !== 1'b0 || illegal !== 1'b0) begin
            mismatched++;
            $display("FAIL mem ext_imm=%h carry=%b vld=%b ill=%b required 00000abc/0/0/0", ext_imm, imm_carry, imm_carry_vld, illegal);
        end
    endtask

    task automatic test_branch();
        do_req(2'b10, 24'hFFFFFE, 4'h6);
        compared++;
        if (ext_imm !== 32'hFFFFFFF8 || ext_imm_w !== 64'hFFFFFFFFFFFFFFF8 || imm_carry_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL br_neg ext_imm=%h w64=%h vld=%b required fffffff8/fffffffffffffff8/0", ext_imm, ext_imm_w, imm_carry_vld);
        end
        do_req(2'b10, 24'h000001, 4'h7);
        compared++;
        if (ext_imm !== 32'h00000004 || ext_imm_w !== 64'h4) begin
            mismatched++;
            $display("FAIL br_pos ext_imm=%h w64=%h required 00000004/4", ext_imm, ext_imm_w);
        end
        do_req(2'b10, 24'h800000, 4'h8);
        compared++;
        if (ext_imm !== 32'hFE000000 || ext_imm_w !== 64'hFFFFFFFFFE000000) begin
            mismatched++;
            $display("FAIL br_min ext_imm=%h w64=%h required fe000000/fffffffffe000000", ext_imm, ext_imm_w);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            do_req(2'b11, 24'h123456, 4'(9 + i));
            compared++;
            if (ext_imm !== 32'h0 || illegal !== 1'b1 || imm_carry_vld !== 1'b0 || illegal_w !== 1'b1) begin
                mismatched++;
                $display("FAIL ill_result idx=%0d ext_imm=%h ill=%b vld=%b ill_w=%b required 0/1/0/1", i, ext_imm, illegal, imm_carry_vld, illegal_w);
            end
        end
        compared++;
        if (illegal_cnt !== 16'd3 || illegal_cnt_w !== 2'd3) begin
            mismatched++;
            $display("FAIL ill_cnt3 cnt=%0d cnt_w=%0d required 3/3", illegal_cnt, illegal_cnt_w);
        end
        for (int i = 0; i < 2; i++) do_req(2'b11, 24'h000000, 4'hC);
        compared++;
        if (illegal_cnt !== 16'd5 || illegal_cnt_w !== 2'd3) begin
            mismatched++;
            $display("FAIL ill_sat cnt=%0d cnt_w=%0d required 5/3", illegal_cnt, illegal_cnt_w);
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] got_tag [$];
        int         got_cyc [$];
        logic       will_acc;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 2'b01; in_tag = 4'd1; instr = 24'h000001;
        @(posedge clk); #1 in_tag = 4'd2; instr = 24'h000002;
        @(posedge clk); #1 in_tag = 4'd3; instr = 24'h000003;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1) begin
            mismatched++;
            $display("FAIL bp_full in_ready=%b out_valid=%b out_tag=%0d required 0/1/1", in_ready, out_valid, out_tag);
        end
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || out_tag !== 4'd1 || ext_imm !== 32'h1) begin
            mismatched++;
            $display("FAIL bp_hold in_ready=%b out_tag=%0d ext_imm=%h required 0/1/00000001", in_ready, out_tag, ext_imm);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) begin
                got_tag.push_back(out_tag);
                got_cyc.push_back(c);
            end
            will_acc = in_valid && in_ready;
            @(posedge clk);
            #1 if (will_acc) in_valid = 1'b0;
            @(negedge clk);
        end
        compared++;
        if (got_tag.size() != 3) begin
            mismatched++;
            $display("FAIL bp_count results=%0d required 3", got_tag.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                compared++;
                if (got_tag[k] !== 4'(k + 1) || got_cyc[k] != k) begin
                    mismatched++;
                    $display("FAIL bp_order idx=%0d tag=%0d cycle=%0d required %0d/%0d", k, got_tag[k], got_cyc[k], k + 1, k);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 2'b11; in_tag = 4'd5;
        @(posedge clk); #1 in_tag = 4'd6;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || illegal_cnt === 16'd0) begin
            mismatched++;
            $display("FAIL rst_mid_pre in_ready=%b out_valid=%b cnt=%0d required 0/1/nonzero", in_ready, out_valid, illegal_cnt);
        end
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || illegal_cnt !== 16'd0 || in_ready !== 1'b0 || illegal !== 1'b0 || out_tag !== 4'd0) begin
            mismatched++;
            $display("FAIL rst_mid out_valid=%b cnt=%0d in_ready=%b ill=%b tag=%0d required 0/0/0/0/0", out_valid, illegal_cnt, in_ready, illegal, out_tag);
        end
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || out_valid_w !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_stale out_valid=%b out_valid_w=%b required 0/0", out_valid, out_valid_w);
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_mem();
        test_branch();
        test_illegal();
        test_back_pressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
